// File: rtl/ysyx_040066_trap_ctrl_pkg.sv
// Shared constants and types for the trap sequencer.
package ysyx_040066_trap_ctrl_pkg;

  localparam int unsigned XlenDefault     = 64;
  localparam logic [63:0] IrqCauseDefault = 64'h8000_0000_0000_0007;

  // mstatus.MIE and mie.MTIE bit positions
  localparam int unsigned MstatusMieBit = 3;
  localparam int unsigned MieMtieBit    = 7;

  // Sequencer state encodings
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StFire  = 2'd2;

  // What the pending request issues once the pipeline has drained
  typedef enum logic {
    KindTrap = 1'b0,
    KindRet  = 1'b1
  } trap_kind_e;

endpackage

// File: rtl/ysyx_040066_trap_ctrl_if.sv
// Pipeline/CSR-side signal bundle of the trap sequencer.
interface ysyx_040066_trap_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  // pipeline and CSR file -> sequencer
  logic            exc_valid;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_tval;
  logic [XLEN-1:0] exc_pc;
  logic            mret_req;
  logic            commit_valid;
  logic [XLEN-1:0] commit_npc;
  logic            timer_irq;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mstatus;
  logic            csr_wen;
  logic            mem_busy;
  // sequencer -> CSR file and pipeline
  logic            raise_intr;
  logic [XLEN-1:0] no;
  logic [XLEN-1:0] tval;
  logic [XLEN-1:0] pc;
  logic            ret;
  logic            clear_mip;
  logic            flush;
  logic            stall_fetch;
  logic            busy;

  modport master (
    output exc_valid, exc_code, exc_tval, exc_pc, mret_req, commit_valid, commit_npc,
           timer_irq, mie, mstatus, csr_wen, mem_busy,
    input  raise_intr, no, tval, pc, ret, clear_mip, flush, stall_fetch, busy
  );

  modport slave (
    input  exc_valid, exc_code, exc_tval, exc_pc, mret_req, commit_valid, commit_npc,
           timer_irq, mie, mstatus, csr_wen, mem_busy,
    output raise_intr, no, tval, pc, ret, clear_mip, flush, stall_fetch, busy
  );

endinterface

// File: rtl/ysyx_040066_trap_sel.sv
// Combinational priority select of the incoming request: exception > mret > interrupt.
module ysyx_040066_trap_sel
  import ysyx_040066_trap_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] IRQ_CAUSE = XLEN'(IrqCauseDefault)
) (
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_code_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            mret_req_i,
  input  logic            irq_ok_i,
  input  logic [XLEN-1:0] commit_npc_i,
  output logic            valid_o,
  output trap_kind_e      kind_o,
  output logic            is_irq_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] tval_o,
  output logic [XLEN-1:0] pc_o
);

  // Pick the highest-priority request and form its cause/tval/epc
  always_comb begin
    valid_o  = 1'b0;
    kind_o   = KindTrap;
    is_irq_o = 1'b0;
    cause_o  = '0;
    tval_o   = '0;
    pc_o     = '0;
    if (exc_valid_i) begin
      valid_o = 1'b1;
      cause_o = XLEN'(exc_code_i);
      tval_o  = exc_tval_i;
      pc_o    = exc_pc_i;
    end else if (mret_req_i) begin
      valid_o = 1'b1;
      kind_o  = KindRet;
    end else if (irq_ok_i) begin
      valid_o  = 1'b1;
      is_irq_o = 1'b1;
      cause_o  = IRQ_CAUSE;
      // Interrupt returns to the instruction after the one retiring now
      pc_o     = commit_npc_i;
    end
  end

endmodule

// File: rtl/ysyx_040066_trap_ctrl.sv
// Trap sequencer: captures a trap/mret/timer request, waits for the pipeline to drain,
// then issues a single raise_intr or ret strobe to the CSR file.
module ysyx_040066_trap_ctrl
  import ysyx_040066_trap_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] IRQ_CAUSE = XLEN'(IrqCauseDefault)
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_040066_trap_ctrl_if.slave trap_io
);

  logic [1:0]      state_q, state_d;
  trap_kind_e      kind_q, kind_d;
  logic            is_irq_q, is_irq_d;
  logic            irq_taken_q, irq_taken_d;
  logic [XLEN-1:0] no_q, no_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic            irq_ok;
  logic            capture;
  logic            fire;
  logic            clr_mip;

  logic            sel_valid;
  trap_kind_e      sel_kind;
  logic            sel_is_irq;
  logic [XLEN-1:0] sel_cause;
  logic [XLEN-1:0] sel_tval;
  logic [XLEN-1:0] sel_pc;

  // Only the MIE/MTIE bits matter; fold the rest so they are visibly consumed
  logic unused_csr_bits;
  assign unused_csr_bits = ^{trap_io.mie, trap_io.mstatus};

  // Timer interrupt is taken at most once per level-high episode
  always_comb begin
    irq_ok = trap_io.timer_irq & trap_io.mstatus[MstatusMieBit] & trap_io.mie[MieMtieBit] &
             trap_io.commit_valid & ~irq_taken_q;
  end

  ysyx_040066_trap_sel #(
    .XLEN      (XLEN),
    .IRQ_CAUSE (IRQ_CAUSE)
  ) u_trap_sel (
    .exc_valid_i  (trap_io.exc_valid),
    .exc_code_i   (trap_io.exc_code),
    .exc_tval_i   (trap_io.exc_tval),
    .exc_pc_i     (trap_io.exc_pc),
    .mret_req_i   (trap_io.mret_req),
    .irq_ok_i     (irq_ok),
    .commit_npc_i (trap_io.commit_npc),
    .valid_o      (sel_valid),
    .kind_o       (sel_kind),
    .is_irq_o     (sel_is_irq),
    .cause_o      (sel_cause),
    .tval_o       (sel_tval),
    .pc_o         (sel_pc)
  );

  // Next state, capture registers and the irq_taken flag
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    is_irq_d    = is_irq_q;
    no_d        = no_q;
    tval_d      = tval_q;
    pc_d        = pc_q;
    irq_taken_d = irq_taken_q;

    capture = (state_q == StIdle) & sel_valid & ~rst;
    // The CSR file ignores raise_intr during a write, so never fire alongside csr_wen
    fire    = (state_q == StFire) & ~trap_io.csr_wen & ~rst;
    // Deferred by a cycle if it would collide with a trap/ret strobe
    clr_mip = irq_taken_q & ~trap_io.timer_irq & ~fire & ~rst;

    case (state_q)
      StIdle: begin
        if (capture) begin
          state_d  = StDrain;
          kind_d   = sel_kind;
          is_irq_d = sel_is_irq;
          if (sel_kind == KindTrap) begin
            no_d   = sel_cause;
            tval_d = sel_tval;
            pc_d   = sel_pc;
          end
        end
      end
      StDrain: begin
        if (!(trap_io.mem_busy || trap_io.csr_wen)) state_d = StFire;
      end
      StFire: begin
        state_d = trap_io.csr_wen ? StDrain : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (fire && (kind_q == KindTrap) && is_irq_q) begin
      irq_taken_d = 1'b1;
    end else if (clr_mip) begin
      irq_taken_d = 1'b0;
    end
  end

  // Strobes and pipeline control decoded from the registered state
  always_comb begin
    trap_io.raise_intr  = fire & (kind_q == KindTrap);
    trap_io.ret         = fire & (kind_q == KindRet);
    trap_io.clear_mip   = clr_mip;
    trap_io.busy        = (state_q != StIdle);
    // Flush starts in the capture cycle so the pipeline drops the request at once
    trap_io.flush       = capture | (state_q != StIdle);
    trap_io.stall_fetch = capture | (state_q != StIdle);
    trap_io.no          = no_q;
    trap_io.tval        = tval_q;
    trap_io.pc          = pc_q;
  end

  // State and capture registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      kind_q      <= KindTrap;
      is_irq_q    <= 1'b0;
      irq_taken_q <= 1'b0;
      no_q        <= '0;
      tval_q      <= '0;
      pc_q        <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      is_irq_q    <= is_irq_d;
      irq_taken_q <= irq_taken_d;
      no_q        <= no_d;
      tval_q      <= tval_d;
      pc_q        <= pc_d;
    end
  end

endmodule

// File: tb/tb_ysyx_040066_trap_ctrl.sv
// Bench for the trap sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model.
module tb_ysyx_040066_trap_ctrl;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] IrqCause = 64'h8000_0000_0000_0007;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ysyx_040066_trap_ctrl_if #(.XLEN(XLEN)) tif ();

  ysyx_040066_trap_ctrl #(
    .XLEN      (XLEN),
    .IRQ_CAUSE (IrqCause)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trap_io (tif.slave)
  );

  int n_cmp;
  int n_err;
  int cyc;

  // Behavioural model: a request is "in flight" from capture until it fires.
  // It fires on the first cycle at least two after capture whose previous cycle
  // was free of mem_busy/csr_wen and which itself has no csr_wen.
  bit          m_inflight;
  int          m_age;
  bit          m_prev_quiet;
  bit          m_kind_ret;
  bit          m_irq;
  bit          m_taken;
  logic [63:0] m_no, m_tval, m_pc;

  // Observed strobe statistics
  int          n_raise, n_ret, n_clr, n_flush, n_busy;
  int          last_raise_cyc, last_ret_cyc;
  logic [63:0] last_raise_no, last_raise_pc, last_raise_tval;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    tif.exc_valid    = 1'b0;
    tif.exc_code     = 4'd0;
    tif.exc_tval     = '0;
    tif.exc_pc       = '0;
    tif.mret_req     = 1'b0;
    tif.commit_valid = 1'b0;
    tif.commit_npc   = '0;
    tif.timer_irq    = 1'b0;
    tif.mie          = '0;
    tif.mstatus      = '0;
    tif.csr_wen      = 1'b0;
    tif.mem_busy     = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, move past the edge
  task automatic step();
    logic irq_ok, e_fire, req, e_clr;
    @(negedge clk);
    irq_ok = tif.timer_irq & tif.mstatus[3] & tif.mie[7] & tif.commit_valid & ~m_taken;
    e_fire = m_inflight && (m_age >= 2) && m_prev_quiet && !tif.csr_wen && !rst;
    req    = !m_inflight && !rst && (tif.exc_valid || tif.mret_req || irq_ok);
    e_clr  = m_taken && !tif.timer_irq && !e_fire && !rst;

    check("raise_intr", 64'(tif.raise_intr), 64'(e_fire && !m_kind_ret));
    check("ret", 64'(tif.ret), 64'(e_fire && m_kind_ret));
    check("clear_mip", 64'(tif.clear_mip), 64'(e_clr));
    check("flush", 64'(tif.flush), 64'(m_inflight || req));
    check("stall_fetch", 64'(tif.stall_fetch), 64'(m_inflight || req));
    check("busy", 64'(tif.busy), 64'(m_inflight));
    check("no", tif.no, m_no);
    check("tval", tif.tval, m_tval);
    check("pc", tif.pc, m_pc);

    if (tif.raise_intr === 1'b1) begin
      n_raise++;
      last_raise_cyc  = cyc;
      last_raise_no   = tif.no;
      last_raise_pc   = tif.pc;
      last_raise_tval = tif.tval;
    end
    if (tif.ret === 1'b1) begin
      n_ret++;
      last_ret_cyc = cyc;
    end
    if (tif.clear_mip === 1'b1) n_clr++;
    if (tif.flush === 1'b1) n_flush++;
    if (tif.busy === 1'b1) n_busy++;

    if (rst) begin
      m_inflight = 1'b0;
      m_age      = 0;
      m_kind_ret = 1'b0;
      m_irq      = 1'b0;
      m_taken    = 1'b0;
      m_no       = '0;
      m_tval     = '0;
      m_pc       = '0;
    end else begin
      if (e_clr) m_taken = 1'b0;
      if (m_inflight) begin
        if (e_fire) begin
          m_inflight = 1'b0;
          if (!m_kind_ret && m_irq) m_taken = 1'b1;
        end else begin
          m_age++;
        end
      end else if (req) begin
        m_inflight = 1'b1;
        m_age      = 1;
        if (tif.exc_valid) begin
          m_kind_ret = 1'b0;
          m_irq      = 1'b0;
          m_no       = {60'd0, tif.exc_code};
          m_tval     = tif.exc_tval;
          m_pc       = tif.exc_pc;
        end else if (tif.mret_req) begin
          m_kind_ret = 1'b1;
          m_irq      = 1'b0;
        end else begin
          m_kind_ret = 1'b0;
          m_irq      = 1'b1;
          m_no       = IrqCause;
          m_tval     = '0;
          m_pc       = tif.commit_npc;
        end
      end
    end
    m_prev_quiet = !tif.mem_busy && !tif.csr_wen;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int cap, b_raise, b_ret, b_clr, b_flush, b_busy;
    n_cmp = 0; n_err = 0; cyc = 0;
    n_raise = 0; n_ret = 0; n_clr = 0; n_flush = 0; n_busy = 0;
    last_raise_cyc = -1; last_ret_cyc = -1;
    last_raise_no = '0; last_raise_pc = '0; last_raise_tval = '0;
    m_inflight = 1'b0; m_age = 0; m_prev_quiet = 1'b0; m_kind_ret = 1'b0;
    m_irq = 1'b0; m_taken = 1'b0; m_no = '0; m_tval = '0; m_pc = '0;

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step();  // reset state checked against the cleared model
    rst = 1'b0;
    step();

    // Exception on an idle pipeline
    b_raise = n_raise; b_flush = n_flush;
    tif.exc_valid = 1'b1; tif.exc_code = 4'd2;
    tif.exc_pc = 64'h8000_0010; tif.exc_tval = 64'hdead;
    cap = cyc;
    step();
    tif.exc_valid = 1'b0;
    repeat (4) step();
    check("t1_raise_cnt", 64'(n_raise - b_raise), 64'd1);
    check("t1_raise_lat", 64'(last_raise_cyc - cap), 64'd2);
    check("t1_no", last_raise_no, 64'd2);
    check("t1_pc", last_raise_pc, 64'h8000_0010);
    check("t1_tval", last_raise_tval, 64'hdead);
    check("t1_flush_cycles", 64'(n_flush - b_flush), 64'd3);

    // mret with the LSU busy for three cycles
    b_raise = n_raise; b_ret = n_ret;
    tif.mret_req = 1'b1;
    cap = cyc;
    step();
    tif.mret_req = 1'b0; tif.mem_busy = 1'b1;
    repeat (3) step();
    tif.mem_busy = 1'b0;
    repeat (4) step();
    check("t2_ret_cnt", 64'(n_ret - b_ret), 64'd1);
    check("t2_ret_lat", 64'(last_ret_cyc - cap), 64'd5);
    check("t2_raise_cnt", 64'(n_raise - b_raise), 64'd0);

    // Timer interrupt, held high: one trap only, then one clear_mip when it drops
    b_raise = n_raise;
    tif.mstatus = 64'h8; tif.mie = 64'h80; tif.timer_irq = 1'b1;
    tif.commit_valid = 1'b1; tif.commit_npc = 64'h8000_0100;
    cap = cyc;
    repeat (10) step();
    check("t3_raise_cnt", 64'(n_raise - b_raise), 64'd1);
    check("t3_raise_lat", 64'(last_raise_cyc - cap), 64'd2);
    check("t3_no", last_raise_no, IrqCause);
    check("t3_pc", last_raise_pc, 64'h8000_0100);
    check("t3_tval", last_raise_tval, 64'd0);
    b_clr = n_clr;
    tif.timer_irq = 1'b0;
    repeat (4) step();
    check("t3_clear_mip_cnt", 64'(n_clr - b_clr), 64'd1);

    // Same interrupt with mstatus.MIE clear: nothing happens
    b_raise = n_raise; b_busy = n_busy;
    tif.mstatus = 64'h0; tif.timer_irq = 1'b1;
    repeat (6) step();
    check("t4_raise_cnt", 64'(n_raise - b_raise), 64'd0);
    check("t4_busy_cycles", 64'(n_busy - b_busy), 64'd0);
    idle_inputs();
    step();

    // Exception and mret together; csr_wen in FIRE withholds the strobe
    b_raise = n_raise; b_ret = n_ret;
    tif.exc_valid = 1'b1; tif.mret_req = 1'b1; tif.exc_code = 4'd5;
    tif.exc_pc = 64'h8000_0200; tif.exc_tval = 64'h1234;
    cap = cyc;
    step();
    tif.exc_valid = 1'b0; tif.mret_req = 1'b0;
    step();
    tif.csr_wen = 1'b1;
    step();
    tif.csr_wen = 1'b0;
    repeat (4) step();
    check("t5_raise_cnt", 64'(n_raise - b_raise), 64'd1);
    check("t5_ret_cnt", 64'(n_ret - b_ret), 64'd0);
    check("t5_raise_lat", 64'(last_raise_cyc - cap), 64'd4);
    check("t5_no", last_raise_no, 64'd5);

    // Reset while draining
    b_raise = n_raise;
    tif.exc_valid = 1'b1; tif.exc_code = 4'd7;
    step();
    tif.exc_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_busy", 64'(tif.busy), 64'd0);
    check("t6_flush", 64'(tif.flush), 64'd0);
    check("t6_no", tif.no, 64'd0);
    repeat (4) step();
    check("t6_raise_cnt", 64'(n_raise - b_raise), 64'd0);

    // Random traffic
    repeat (400) begin
      tif.exc_valid    = ($urandom % 6) == 0;
      tif.mret_req     = ($urandom % 8) == 0;
      tif.exc_code     = 4'($urandom);
      tif.exc_tval     = {$urandom, $urandom};
      tif.exc_pc       = {$urandom, $urandom};
      tif.commit_valid = ($urandom % 2) == 0;
      tif.commit_npc   = {$urandom, $urandom};
      if (($urandom % 12) == 0) tif.timer_irq = ~tif.timer_irq;
      tif.mstatus      = {$urandom, $urandom};
      tif.mie          = {$urandom, $urandom};
      tif.csr_wen      = ($urandom % 4) == 0;
      tif.mem_busy     = ($urandom % 3) == 0;
      rst              = ($urandom % 80) == 0;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
